// File: rtl/mod_check_sched.sv
// Shared serial modulo checker with a round-robin front end.
// Grants one requester word at a time and shifts it MSB-first through a remainder tracker.
module mod_check_sched #(
    parameter int NREQ = 4,
    parameter int W = 8,
    parameter int DIV = 3,
    localparam int RW = $clog2(DIV),
    localparam int IW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0] req_ready,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_div,
    output logic [RW-1:0]   res_rem,
    output logic [IW-1:0]   res_id,
    output logic            busy
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [RW-1:0] rem;
    logic [CW-1:0] cnt;
    logic [W-1:0]  shreg;

    logic [W-1:0]  words [NREQ];
    logic [IW:0]   cand;
    logic [IW-1:0] gnt;
    logic          found;
    logic [IW-1:0] ptr_nx;
    logic [RW:0]   t;
    logic [RW-1:0] rem_nx;

    // Unpack the flat request bus into one word per requester
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            words[i] = req_data[i*W +: W];
        end
    end

    // Round-robin search: first valid requester starting at ptr, wrapping
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!found && req_valid[cand[IW-1:0]]) begin
                found = 1'b1;
                gnt   = cand[IW-1:0];
            end
        end
    end

    assign ptr_nx = (gnt == IW'(NREQ - 1)) ? '0 : gnt + IW'(1);

    // One remainder step: t = 2*rem + bit, then a single conditional subtract
    assign t      = {rem, shreg[W-1]};
    assign rem_nx = (t >= (RW+1)'(DIV)) ? RW'(t - (RW+1)'(DIV)) : t[RW-1:0];

    assign req_ready = (!reset && state == IDLE && found) ? (NREQ'(1) << gnt) : '0;
    assign busy      = (state != IDLE);

    // Arbitration, shifting and result-holding state machine
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            rem       <= '0;
            cnt       <= '0;
            shreg     <= '0;
            res_valid <= 1'b0;
            res_div   <= 1'b0;
            res_rem   <= '0;
            res_id    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        shreg  <= words[gnt];
                        res_id <= gnt;
                        rem    <= '0;
                        cnt    <= '0;
                        ptr    <= ptr_nx;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg <= shreg << 1;
                    rem   <= rem_nx;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_rem   <= rem_nx;
                        res_div   <= (rem_nx == '0);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_check_sched.sv
// Self-checking bench for mod_check_sched.
// Table-driven jobs plus hand-written arbitration, backpressure, reset and sweep sequences.
module tb_mod_check_sched;

    localparam int NREQ = 4;
    localparam int W = 8;
    localparam int DIV = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        res_div;
    logic [1:0]  res_rem;
    logic [1:0]  res_id;
    logic        busy;

    logic [3:0]  rv5 = '0;
    logic [31:0] rd5 = '0;
    logic [3:0]  rdy5;
    logic        resv5;
    logic        rr5 = 1'b1;
    logic        rdiv5;
    logic [2:0]  rrem5;
    logic [1:0]  rid5;
    logic        busy5;

    mod_check_sched #(.NREQ(4), .W(8), .DIV(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_div(res_div), .res_rem(res_rem), .res_id(res_id),
        .busy(busy)
    );

    mod_check_sched #(.NREQ(4), .W(8), .DIV(5)) dut5 (
        .clk(clk), .reset(reset),
        .req_valid(rv5), .req_data(rd5), .req_ready(rdy5),
        .res_valid(resv5), .res_ready(rr5),
        .res_div(rdiv5), .res_rem(rrem5), .res_id(rid5),
        .busy(busy5)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int data;
        int rem;
        int dv;
    } vec_t;

    typedef struct {
        int id;
        int rem;
        int dv;
    } exp_t;

    vec_t tbl [6];
    exp_t sbq [$];
    int   ncmp = 0;
    int   nbad = 0;
    int   gcnt = 0;
    int   cyc = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail(string nm);
        ncmp++;
        nbad++;
        $display("FAIL %s", nm);
    endtask

    task automatic monitor();
        exp_t e;
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && req_valid[i]) gcnt++;
            end
            if (busy) check("ready_while_busy", 32'(req_ready), 0);
            if (res_valid && res_ready) begin
                if (sbq.size() == 0) begin
                    fail("unexpected_result");
                end else begin
                    e = sbq.pop_front();
                    check("res_id", 32'(res_id), e.id);
                    check("res_rem", 32'(res_rem), e.rem);
                    check("res_div", 32'(res_div), e.dv);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_word(int id, int d);
        req_data[id*W +: W] = 8'(d);
    endtask

    task automatic push_exp(int id, int d);
        int r;
        r = d % DIV;
        sbq.push_back('{id: id, rem: r, dv: (r == 0) ? 1 : 0});
    endtask

    task automatic offer(logic [3:0] mask, int n);
        int target;
        target = gcnt + n;
        req_valid = mask;
        for (int k = 0; k < 200 && gcnt < target; k++) tick();
        if (gcnt < target) fail("grant_timeout");
        req_valid = '0;
    endtask

    task automatic wait_res();
        for (int k = 0; k < 40 && !res_valid; k++) tick();
        if (!res_valid) fail("result_timeout");
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (sbq.size() != 0 || busy); k++) tick();
        if (sbq.size() != 0 || busy) fail("drain_timeout");
    endtask

    task automatic run_job(vec_t v);
        int a;
        drain();
        set_word(v.id, v.data);
        sbq.push_back('{id: v.id, rem: v.rem, dv: v.dv});
        res_ready = 1'b1;
        req_valid = 4'(1 << v.id);
        #1;
        check("grant_onehot", 32'(req_ready), 1 << v.id);
        tick();
        req_valid = '0;
        a = cyc;
        #1;
        check("ready_one_cycle", 32'(req_ready), 0);
        check("busy_after_accept", 32'(busy), 1);
        wait_res();
        check("latency", cyc - a, W);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{id: 2, data: 100, rem: 1, dv: 0};
        tbl[1] = '{id: 2, data: 255, rem: 0, dv: 1};
        tbl[2] = '{id: 2, data: 0,   rem: 0, dv: 1};
        tbl[3] = '{id: 0, data: 7,   rem: 1, dv: 0};
        tbl[4] = '{id: 3, data: 200, rem: 2, dv: 0};
        tbl[5] = '{id: 1, data: 1,   rem: 1, dv: 0};

        // reset values with every requester valid
        req_valid = 4'hF;
        req_data = 32'hFFFF_FFFF;
        #3;
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_div", 32'(res_div), 0);
        check("rst_res_rem", 32'(res_rem), 0);
        check("rst_res_id", 32'(res_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        req_valid = '0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_busy", 32'(busy), 0);
            check("idle_ready", 32'(req_ready), 0);
        end

        // single jobs from the table
        for (int i = 0; i < 6; i++) run_job(tbl[i]);
        drain();

        // fairness, all four valid from ptr 0
        reset = 1'b1;
        sbq.delete();
        tick();
        reset = 1'b0;
        set_word(0, 7);
        set_word(1, 50);
        set_word(2, 100);
        set_word(3, 9);
        res_ready = 1'b1;
        push_exp(0, 7);
        push_exp(1, 50);
        push_exp(2, 100);
        push_exp(3, 9);
        push_exp(0, 7);
        offer(4'hF, 5);
        drain();

        // fairness, only 1 and 3 valid
        push_exp(1, 50);
        push_exp(3, 9);
        push_exp(1, 50);
        push_exp(3, 9);
        offer(4'b1010, 4);
        drain();

        // result backpressure
        res_ready = 1'b0;
        set_word(2, 100);
        push_exp(2, 100);
        offer(4'b0100, 1);
        wait_res();
        set_word(1, 50);
        push_exp(1, 50);
        req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(res_valid), 1);
            check("bp_rem", 32'(res_rem), 1);
            check("bp_id", 32'(res_id), 2);
            check("bp_div", 32'(res_div), 0);
            check("bp_ready", 32'(req_ready), 0);
        end
        res_ready = 1'b1;
        tick();
        check("bp_drop_valid", 32'(res_valid), 0);
        check("bp_idle", 32'(busy), 0);
        check("bp_next_grant", 32'(req_ready), 4'b0010);
        tick();
        req_valid = '0;
        check("bp_next_busy", 32'(busy), 1);
        drain();

        // reset in the middle of a shift
        set_word(2, 100);
        push_exp(2, 100);
        offer(4'b0100, 1);
        repeat (3) tick();
        req_valid = 4'b0010;
        #1;
        reset = 1'b1;
        sbq.delete();
        #1;
        check("mid_rst_valid", 32'(res_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(req_ready), 0);
        check("mid_rst_id", 32'(res_id), 0);
        check("mid_rst_rem", 32'(res_rem), 0);
        check("mid_rst_div", 32'(res_div), 0);
        tick();
        check("rst_hold_ready", 32'(req_ready), 0);
        req_valid = '0;
        #1;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("no_lost_result", 32'(res_valid), 0);
        end
        set_word(0, 100);
        set_word(3, 5);
        push_exp(0, 100);
        push_exp(3, 5);
        offer(4'b1001, 2);
        drain();

        // DIV=5 sweep over every word on requester 0
        for (int w = 0; w < 256; w++) begin
            rd5[7:0] = 8'(w);
            rv5 = 4'b0001;
            #1;
            check("sweep_grant", 32'(rdy5), 1);
            tick();
            rv5 = '0;
            for (int k = 0; k < 20 && !resv5; k++) tick();
            if (!resv5) begin
                fail("sweep_timeout");
            end else begin
                check("sweep_rem", 32'(rrem5), w % 5);
                check("sweep_div", 32'(rdiv5), (w % 5 == 0) ? 1 : 0);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
